// File: rtl/uart_status_pkg.sv
// Shared constants and state encodings for the UART status transmitter.
package uart_status_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 4;

  typedef enum logic [1:0] {IDLE, SEND, DONE} top_state_e;
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_e;

  function automatic logic [7:0] frame_checksum(input logic [7:0] b0,
                                                input logic [7:0] b1,
                                                input logic [7:0] b2);
    return b0 ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/uart_status_tx_if.sv
// Status inputs and UART outputs of the status transmitter.
interface uart_status_tx_if #(
  parameter int COUNT_WIDTH = 4
);
  logic                   enable_i;
  logic [7:0]             channels_i;
  logic [COUNT_WIDTH-1:0] ones_count_i;
  logic                   tx_o;
  logic                   busy_o;
  logic                   frame_done_o;

  modport master (output enable_i, channels_i, ones_count_i,
                  input  tx_o, busy_o, frame_done_o);
  modport slave  (input  enable_i, channels_i, ones_count_i,
                  output tx_o, busy_o, frame_done_o);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; a new byte may be accepted on the last stop-bit cycle
// so consecutive bytes are contiguous on the line.
module uart_tx_byte
  import uart_status_pkg::*;
#(
  parameter int BAUD_DIV = 104
) (
  input  logic       clock_i,
  input  logic       reset_n_i,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       tx_o,
  output logic       ready_o,
  output logic       done_o
);
  localparam int              CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign ready_o = (state_q == S_IDLE) || ((state_q == S_STOP) && bit_end);
  assign done_o  = (state_q == S_STOP) && bit_end;
  assign tx_o    = tx_q;

  // NOTE: every _d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cnt_d   = (state_q == S_IDLE || bit_end) ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = S_STOP;
      end
      S_STOP: if (bit_end) state_d = S_IDLE;
      default: ;
    endcase

    if (start_i && ready_o) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = data_i;
    end

    // Line level is registered from the next state to keep tx_o glitch-free.
    tx_d = (state_d == S_DATA) ? shift_d[0] : (state_d != S_START);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: rtl/uart_status_tx.sv
// Sends {SYNC, channels, ones, checksum} frames on channel change or heartbeat.
module uart_status_tx
  import uart_status_pkg::*;
#(
  parameter int CLOCK_HZ         = 1000000,
  parameter int BAUD_RATE        = 9600,
  parameter int BAUD_DIV         = CLOCK_HZ / BAUD_RATE,
  parameter int HEARTBEAT_CYCLES = 100000,
  parameter int COUNT_WIDTH      = 4
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  uart_status_tx_if.slave   bus
);
  localparam int            HB_W     = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'((HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0);
  localparam logic [1:0]    LAST_IDX = 2'(FRAME_BYTES - 1);

  top_state_e             state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [7:0]             last_q, last_d;
  logic                   pending_q, pending_d;
  logic [HB_W-1:0]        hb_q, hb_d;
  logic [7:0]             ch_snap_q, ch_snap_d;
  logic [COUNT_WIDTH-1:0] ones_snap_q, ones_snap_d;

  logic       ser_start, ser_ready, ser_done, ser_tx;
  logic [7:0] ser_data;
  logic [1:0] next_idx;
  logic       hb_hit, trigger;

  // Bytes 1..3 are issued after the snapshot registers have been loaded.
  function automatic logic [7:0] frame_byte(input logic [1:0] idx,
                                            input logic [7:0] ch,
                                            input logic [COUNT_WIDTH-1:0] ones);
    case (idx)
      2'd0:    return SYNC_BYTE;
      2'd1:    return ch;
      2'd2:    return 8'(ones);
      default: return frame_checksum(SYNC_BYTE, ch, 8'(ones));
    endcase
  endfunction

  assign next_idx = (state_q == IDLE) ? 2'd0 : idx_q + 2'd1;
  assign ser_data = frame_byte(next_idx, ch_snap_q, ones_snap_q);
  assign hb_hit   = (HEARTBEAT_CYCLES != 0) && (hb_q == HB_LAST);
  assign trigger  = bus.enable_i && ser_ready &&
                    ((bus.channels_i != last_q) || pending_q || hb_hit);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    pending_d   = pending_q;
    hb_d        = hb_q;
    ch_snap_d   = ch_snap_q;
    ones_snap_d = ones_snap_q;
    ser_start   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable_i && hb_q != HB_LAST) hb_d = hb_q + 1'b1;
        if (trigger) begin
          ser_start   = 1'b1;
          state_d     = SEND;
          idx_d       = 2'd0;
          ch_snap_d   = bus.channels_i;
          ones_snap_d = bus.ones_count_i;
          last_d      = bus.channels_i;
          pending_d   = 1'b0;
          hb_d        = '0;
        end
      end
      SEND: begin
        if (bus.channels_i != last_q) pending_d = 1'b1;
        if (ser_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            ser_start = 1'b1;
            idx_d     = idx_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      last_q      <= 8'h00;
      pending_q   <= 1'b0;
      hb_q        <= '0;
      ch_snap_q   <= '0;
      ones_snap_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      pending_q   <= pending_d;
      hb_q        <= hb_d;
      ch_snap_q   <= ch_snap_d;
      ones_snap_q <= ones_snap_d;
    end
  end

  uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_ser (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .data_i    (ser_data),
    .start_i   (ser_start),
    .tx_o      (ser_tx),
    .ready_o   (ser_ready),
    .done_o    (ser_done)
  );

  assign bus.tx_o         = ser_tx;
  assign bus.busy_o       = (state_q == SEND);
  assign bus.frame_done_o = (state_q == DONE);

endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench: decodes UART frames bit-by-bit and checks timing and content.
`timescale 1ns/1ps
module tb_uart_status_tx;
  localparam int BIT_CYC   = 104;
  localparam int FRAME_CYC = 40 * BIT_CYC;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic sel = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  uart_status_tx_if #(.COUNT_WIDTH(4)) bus_a ();
  uart_status_tx_if #(.COUNT_WIDTH(4)) bus_b ();

  uart_status_tx #(.HEARTBEAT_CYCLES(0)) dut_a (
    .clock_i (clk), .reset_n_i (rst_a), .bus (bus_a.slave)
  );
  uart_status_tx #(.HEARTBEAT_CYCLES(1000)) dut_b (
    .clock_i (clk), .reset_n_i (rst_b), .bus (bus_b.slave)
  );

  logic tx_m, busy_m, done_m;
  assign tx_m   = sel ? bus_b.tx_o         : bus_a.tx_o;
  assign busy_m = sel ? bus_b.busy_o       : bus_a.busy_o;
  assign done_m = sel ? bus_b.frame_done_o : bus_a.frame_done_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int max_cyc, output int start_cyc);
    logic seen;
    seen = 1'b0;
    start_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      if (tx_m === 1'b0) begin
        seen = 1'b1;
        start_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("start_seen", seen, 1'b1);
  endtask

  // Called on the first start-bit sample; optionally perturbs DUT A inputs at offset chg_at.
  task automatic recv_frame(input logic [31:0] exp, input int chg_at,
                            input logic [7:0] chg_ch, input logic [3:0] chg_ones,
                            input logic chg_en, output int done_cyc);
    int wave_err, busy_err, done_err, b, k, p;
    logic e;
    logic [7:0] got [4];
    wave_err = 0; busy_err = 0; done_err = 0;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    for (int n = 0; n < FRAME_CYC; n++) begin
      b = n / BIT_CYC;
      k = b / 10;
      p = b % 10;
      e = (p == 0) ? 1'b0 : (p == 9) ? 1'b1 : exp[k*8 + p - 1];
      if (tx_m !== e) wave_err++;
      if (busy_m !== 1'b1) busy_err++;
      if (done_m !== 1'b0) done_err++;
      if ((n % BIT_CYC) == BIT_CYC / 2 && p >= 1 && p <= 8) got[k][p-1] = tx_m;
      if (n == chg_at) begin
        bus_a.channels_i   = chg_ch;
        bus_a.ones_count_i = chg_ones;
        bus_a.enable_i     = chg_en;
      end
      @(negedge clk);
    end
    check("wave_errors", wave_err, 0);
    check("busy_low_in_frame", busy_err, 0);
    check("done_early", done_err, 0);
    check("byte0", got[0], exp[7:0]);
    check("byte1", got[1], exp[15:8]);
    check("byte2", got[2], exp[23:16]);
    check("byte3", got[3], exp[31:24]);
    check("frame_done_pulse", done_m, 1'b1);
    check("busy_after_frame", busy_m, 1'b0);
    check("tx_after_frame", tx_m, 1'b1);
    done_cyc = cyc;
  endtask

  task automatic expect_quiet(input string tag, input int n_cyc);
    int bad;
    bad = 0;
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clk);
      if (tx_m !== 1'b1 || busy_m !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  initial begin
    int c, sc, dc;
    bus_a.enable_i = 1'b1; bus_a.channels_i = 8'h00; bus_a.ones_count_i = 4'd0;
    bus_b.enable_i = 1'b0; bus_b.channels_i = 8'h00; bus_b.ones_count_i = 4'd0;
    #1 rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_a", bus_a.tx_o, 1'b1);
    check("rst_busy_a", bus_a.busy_o, 1'b0);
    check("rst_done_a", bus_a.frame_done_o, 1'b0);
    check("rst_tx_b", bus_b.tx_o, 1'b1);
    rst_a = 1'b1; rst_b = 1'b1;

    // Static channels equal to last_sent with heartbeat disabled: line stays idle.
    expect_quiet("idle_20000", 20000);

    // Change to 0F; mid-frame change to FF/8 queues a second frame.
    bus_a.channels_i = 8'h0F; bus_a.ones_count_i = 4'd4;
    c = cyc;
    wait_start(10, sc);
    check("start_latency", sc, c + 1);
    recv_frame(32'hAE040FA5, 500, 8'hFF, 4'd8, 1'b1, dc);
    wait_start(10, sc);
    check("back_to_back_gap", sc, dc + 2);
    recv_frame(32'h5208FFA5, -1, 8'h00, 4'd0, 1'b1, dc);
    expect_quiet("no_extra_frame", 300);

    // Disabled with a change pending, ones count above 8.
    bus_a.enable_i = 1'b0; bus_a.channels_i = 8'h33; bus_a.ones_count_i = 4'hC;
    expect_quiet("disabled_no_frame", 500);
    bus_a.enable_i = 1'b1;
    c = cyc;
    wait_start(10, sc);
    check("enable_latency", sc, c + 1);
    recv_frame(32'h9A0C33A5, 1100, 8'h55, 4'hC, 1'b0, dc);
    expect_quiet("disabled_after_frame", 2000);

    // Abort a frame in byte2 with reset, then resend after release.
    bus_a.enable_i = 1'b1;
    wait_start(10, sc);
    repeat (2 * 10 * BIT_CYC + 300) @(negedge clk);
    check("byte2_busy_before_rst", bus_a.busy_o, 1'b1);
    rst_a = 1'b0;
    #1;
    check("async_rst_tx", bus_a.tx_o, 1'b1);
    check("async_rst_busy", bus_a.busy_o, 1'b0);
    @(negedge clk);
    bus_a.channels_i = 8'h0F; bus_a.ones_count_i = 4'd4;
    @(negedge clk);
    rst_a = 1'b1;
    c = cyc;
    wait_start(10, sc);
    check("post_rst_latency", sc, c + 1);
    recv_frame(32'hAE040FA5, -1, 8'h0F, 4'd4, 1'b1, dc);

    // Heartbeat instance: counter held while disabled, then 1000-cycle cadence.
    sel = 1'b1;
    bus_b.enable_i = 1'b1;
    c = cyc;
    wait_start(1100, sc);
    check("hb_first_start", sc, c + 1000);
    recv_frame(32'hA50000A5, -1, 8'h0F, 4'd4, 1'b1, dc);
    wait_start(1100, sc);
    check("hb_interval_1", sc, dc + 1001);
    recv_frame(32'hA50000A5, -1, 8'h0F, 4'd4, 1'b1, dc);
    wait_start(1100, sc);
    check("hb_interval_2", sc, dc + 1001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
